// File: rtl/storm_pio_loader.sv
// STORM host program loader: toggle-handshake byte port in, 16-bit IRAM writes out.
// Holds the core in reset while loading and releases it on a RUN command.
module storm_pio_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStb,
  input  logic [1:0]        iCtrl,
  input  logic [7:0]        iPData,
  output logic              oAck,
  output logic [ADDR_W-1:0] oIRAM_Addr,
  output logic [DATA_W-1:0] oIRAM_Data,
  output logic              oIRAM_WE,
  output logic              oCoreRst,
  output logic [15:0]       oSum,
  output logic              oErr
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_ADDR = 2'b01;
  localparam logic [1:0] CMD_DATA = 2'b10;
  localparam logic [1:0] CMD_RUN  = 2'b11;

  typedef enum logic {ST_HALT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                s1, s2, s3;
  logic [1:0]          prime_cnt, prime_cnt_nxt;
  logic                phase, phase_nxt;
  logic [7:0]          hold, hold_nxt;
  logic [1:0]          cmd_q, cmd_q_nxt;
  logic                ack_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                we_nxt;
  logic [15:0]         sum_nxt;
  logic                err_nxt;
  logic                primed;
  logic                evt;
  logic [DATA_W-1:0]   word;

  assign primed   = (prime_cnt == 2'd3);
  assign evt      = primed & (s2 ^ s3);
  assign word     = {hold, iPData};
  assign oCoreRst = (state == ST_HALT);

  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    phase_nxt     = phase;
    hold_nxt      = hold;
    cmd_q_nxt     = cmd_q;
    ack_nxt       = oAck;
    addr_nxt      = oIRAM_Addr;
    data_nxt      = oIRAM_Data;
    we_nxt        = 1'b0;
    sum_nxt       = oSum;
    err_nxt       = oErr;

    // The pointer advances on the edge that ends the write pulse.
    if (oIRAM_WE)
      addr_nxt = oIRAM_Addr + ADDR_W'(1);

    // Until the synchroniser holds real history, just mirror the strobe level.
    if (!primed) begin
      prime_cnt_nxt = prime_cnt + 2'd1;
      ack_nxt       = s2;
    end

    if (evt) begin
      ack_nxt = s2;
      case (iCtrl)
        CMD_NOP: begin
          phase_nxt = 1'b0;
          err_nxt   = 1'b0;
        end
        CMD_ADDR, CMD_DATA: begin
          if (state == ST_RUN) begin
            err_nxt   = 1'b1;
            phase_nxt = 1'b0;
          end else if (!phase) begin
            hold_nxt  = iPData;
            cmd_q_nxt = iCtrl;
            phase_nxt = 1'b1;
          end else if (iCtrl != cmd_q) begin
            err_nxt   = 1'b1;
            phase_nxt = 1'b0;
          end else if (iCtrl == CMD_ADDR) begin
            addr_nxt  = word[ADDR_W-1:0];
            phase_nxt = 1'b0;
          end else begin
            data_nxt  = word;
            we_nxt    = 1'b1;
            sum_nxt   = oSum + 16'(word);
            phase_nxt = 1'b0;
          end
        end
        default: begin
          // HALT is always honoured; RUN only from a clean HALT with no half pair.
          if (!iPData[0]) begin
            state_nxt = ST_HALT;
            sum_nxt   = 16'd0;
            phase_nxt = 1'b0;
          end else if (phase) begin
            err_nxt   = 1'b1;
            phase_nxt = 1'b0;
          end else if (state == ST_HALT) begin
            state_nxt = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= ST_HALT;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      prime_cnt  <= 2'd0;
      phase      <= 1'b0;
      hold       <= 8'd0;
      cmd_q      <= CMD_NOP;
      oAck       <= 1'b0;
      oIRAM_Addr <= '0;
      oIRAM_Data <= '0;
      oIRAM_WE   <= 1'b0;
      oSum       <= 16'd0;
      oErr       <= 1'b0;
    end else begin
      state      <= state_nxt;
      s1         <= iStb;
      s2         <= s1;
      s3         <= s2;
      prime_cnt  <= prime_cnt_nxt;
      phase      <= phase_nxt;
      hold       <= hold_nxt;
      cmd_q      <= cmd_q_nxt;
      oAck       <= ack_nxt;
      oIRAM_Addr <= addr_nxt;
      oIRAM_Data <= data_nxt;
      oIRAM_WE   <= we_nxt;
      oSum       <= sum_nxt;
      oErr       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_storm_pio_loader.sv
// Scoreboard bench for storm_pio_loader: expected IRAM writes are queued as
// stimulus is driven and retired when the loader pulses its write enable.
module tb_storm_pio_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [1:0]  ctrl;
  logic [7:0]  pdata;
  logic        ack;
  logic [8:0]  iram_addr;
  logic [15:0] iram_data;
  logic        iram_we;
  logic        core_rst;
  logic [15:0] sum;
  logic        err;

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic we_prev = 1'b0;

  always #5 clk = ~clk;

  storm_pio_loader #(.ADDR_W(9), .DATA_W(16)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iStb       (stb),
    .iCtrl      (ctrl),
    .iPData     (pdata),
    .oAck       (ack),
    .oIRAM_Addr (iram_addr),
    .oIRAM_Data (iram_data),
    .oIRAM_WE   (iram_we),
    .oCoreRst   (core_rst),
    .oSum       (sum),
    .oErr       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [8:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic xfer(input logic [1:0] c, input logic [7:0] d);
    int n;
    @(negedge clk);
    ctrl  = c;
    pdata = d;
    @(negedge clk);
    stb = ~stb;
    n = 0;
    while (ack !== stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack", {31'd0, ack}, {31'd0, stb});
    repeat (2) @(negedge clk);
  endtask

  // Write monitor: every WE pulse must match the oldest queued write.
  always @(negedge clk) begin
    wr_t e;
    if (we_prev)
      check("we_2cyc", {31'd0, iram_we}, 32'd0);
    if (iram_we) begin
      if (sb.size() == 0) begin
        check("we_unexp", {31'd0, iram_we}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {23'd0, iram_addr}, {23'd0, e.a});
        check("wr_data", {16'd0, iram_data}, {16'd0, e.d});
      end
    end
    we_prev = iram_we;
  end

  initial begin
    logic old_ack;
    rst   = 1'b1;
    stb   = 1'b1;
    ctrl  = 2'b00;
    pdata = 8'h00;

    // Reset values with the strobe held high, then priming.
    repeat (3) @(negedge clk);
    check("rst_ack",  {31'd0, ack},       32'd0);
    check("rst_addr", {23'd0, iram_addr}, 32'd0);
    check("rst_data", {16'd0, iram_data}, 32'd0);
    check("rst_we",   {31'd0, iram_we},   32'd0);
    check("rst_core", {31'd0, core_rst},  32'd1);
    check("rst_sum",  {16'd0, sum},       32'd0);
    check("rst_err",  {31'd0, err},       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("prime_e1", {31'd0, ack}, 32'd0);
    @(negedge clk);
    check("prime_e2", {31'd0, ack}, 32'd0);
    @(negedge clk);
    check("prime_e3", {31'd0, ack}, 32'd1);
    repeat (3) @(negedge clk);
    check("prime_core", {31'd0, core_rst}, 32'd1);
    check("prime_err",  {31'd0, err},      32'd0);

    // Ack latency on a NOP: toggles at the third rising edge.
    ctrl = 2'b00;
    @(negedge clk);
    stb = ~stb;
    old_ack = ack;
    @(negedge clk);
    check("lat_k",  {31'd0, ack}, {31'd0, old_ack});
    @(negedge clk);
    check("lat_k1", {31'd0, ack}, {31'd0, old_ack});
    @(negedge clk);
    check("lat_k2", {31'd0, ack}, {31'd0, stb});
    repeat (2) @(negedge clk);

    // Address load, two writes, pointer wrap and checksum.
    xfer(2'b01, 8'h01);
    xfer(2'b01, 8'hFE);
    check("addr_load", {23'd0, iram_addr}, 32'h1FE);
    push_wr(9'h1FE, 16'h1234);
    xfer(2'b10, 8'h12);
    xfer(2'b10, 8'h34);
    check("addr_inc", {23'd0, iram_addr}, 32'h1FF);
    check("sum1",     {16'd0, sum},       32'h1234);
    push_wr(9'h1FF, 16'hABCD);
    xfer(2'b10, 8'hAB);
    xfer(2'b10, 8'hCD);
    check("addr_wrap", {23'd0, iram_addr}, 32'h000);
    check("sum2",      {16'd0, sum},       32'hBE01);
    check("err_clean", {31'd0, err},       32'd0);

    // Mixed pair is an error with no write; NOP clears it.
    xfer(2'b01, 8'h00);
    xfer(2'b10, 8'h55);
    check("mix_err",  {31'd0, err},       32'd1);
    check("mix_addr", {23'd0, iram_addr}, 32'h000);
    xfer(2'b00, 8'h00);
    check("nop_clr",  {31'd0, err},       32'd0);

    // RUN, ignored data while running, HALT, and RUN after half a pair.
    xfer(2'b11, 8'h01);
    check("run_core", {31'd0, core_rst}, 32'd0);
    xfer(2'b10, 8'h11);
    xfer(2'b10, 8'h22);
    check("run_err",  {31'd0, err},      32'd1);
    check("run_sum",  {16'd0, sum},      32'hBE01);
    xfer(2'b11, 8'h00);
    check("halt_core", {31'd0, core_rst}, 32'd1);
    check("halt_sum",  {16'd0, sum},      32'd0);
    check("halt_err",  {31'd0, err},      32'd1);
    xfer(2'b00, 8'h00);
    check("nop_clr2",  {31'd0, err},      32'd0);
    xfer(2'b10, 8'h11);
    xfer(2'b11, 8'h01);
    check("runhalf_err",  {31'd0, err},      32'd1);
    check("runhalf_core", {31'd0, core_rst}, 32'd1);
    xfer(2'b00, 8'h00);

    // Async reset between the two DATA bytes discards the pending byte.
    xfer(2'b01, 8'h00);
    xfer(2'b01, 8'h07);
    check("addr7", {23'd0, iram_addr}, 32'h007);
    xfer(2'b10, 8'h12);
    #2 rst = 1'b1;
    #1;
    check("arst_core", {31'd0, core_rst},  32'd1);
    check("arst_addr", {23'd0, iram_addr}, 32'd0);
    check("arst_we",   {31'd0, iram_we},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_prime", {31'd0, ack}, {31'd0, stb});
    push_wr(9'h000, 16'h9ABC);
    xfer(2'b10, 8'h9A);
    xfer(2'b10, 8'hBC);
    check("post_addr", {23'd0, iram_addr}, 32'h001);
    check("post_sum",  {16'd0, sum},       32'h9ABC);

    repeat (4) @(negedge clk);
    check("sb_left", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/storm_pio_loader.md
Name: storm_pio_loader

Overview:
- Host-side program loader for STORM. It receives bytes from an external host over a toggle-handshake parallel port and assembles them into 16-bit words.
- It writes those words into instruction RAM, holding the core in reset while loading, and releases the core on a RUN command.
- It is the write end of the instruction-RAM path, sitting between the PIO pins and the IRAM write port.

Parameters:
ADDR_W, 9, instruction RAM address width (512 words)
DATA_W, 16, instruction word width; must equal 2 x 8

Ports:
iClk  in  1  system clock, rising edge
iRst  in  1  asynchronous reset, active-high
iStb  in  1  host strobe; each toggle (either edge) is one transfer; asynchronous to iClk
iCtrl  in  2  command: 00 NOP, 01 ADDR byte, 10 DATA byte, 11 RUN/HALT
iPData  in  8  payload byte; host keeps it and iCtrl stable from before the iStb toggle until oAck == iStb
oAck  out  1  acknowledge; equals iStb level once the transfer is consumed
oIRAM_Addr  out  ADDR_W  IRAM write address / load pointer
oIRAM_Data  out  DATA_W  IRAM write data
oIRAM_WE  out  1  IRAM write enable, single-cycle pulse
oCoreRst  out  1  core reset request; 1 = core held in reset
oSum  out  16  running sum of written words, modulo 2^16
oErr  out  1  sticky protocol error flag

Behaviour:
- Reset (async, iRst=1) values: oAck=0, oIRAM_Addr=0, oIRAM_Data=0, oIRAM_WE=0, oCoreRst=1, oSum=0, oErr=0.
  - Internal reset values: byte phase=0, hold byte=0, stored cmd=00, sync regs s1/s2/s3=0, prime counter=0, state=HALT.
- Synchroniser: s1<=iStb, s2<=s1, s3<=s2 on every edge.
- Priming: for the first 3 edges after reset release, events are suppressed and oAck<=s2. A high iStb at reset release therefore never creates a transfer.
- Event timing: event = s2 XOR s3, after priming. If iStb toggles and edge k is the first edge to sample it into s1, the event is true in the cycle after edge k+1. The action registers at edge k+2:
  - oAck<=s2;
  - iCtrl/iPData are sampled directly (stable by protocol).
- Command effects at the action edge:
  - NOP: phase<=0, oErr<=0.
  - ADDR, DATA, phase 0: hold<=iPData, stored cmd<=iCtrl, phase<=1.
  - ADDR, phase 1, same stored cmd: oIRAM_Addr<={hold,iPData}[ADDR_W-1:0], phase<=0.
  - DATA, phase 1, same stored cmd: oIRAM_Data<={hold,iPData} (high byte first), oIRAM_WE<=1 for exactly one cycle, oSum<=oSum+word (carry dropped), phase<=0.
    - oIRAM_Addr increments at edge k+3 (the edge that drops WE), wrapping 2^ADDR_W-1 -> 0.
  - ADDR/DATA in phase 1 whose cmd differs from the stored cmd: oErr<=1, phase<=0, byte discarded, no write.
  - RUN/HALT with iPData[0]=1, state HALT, phase 0: state<=RUN, oCoreRst<=0.
  - RUN with phase 1: oErr<=1, phase<=0, remain HALT.
  - RUN/HALT with iPData[0]=0: state<=HALT, oCoreRst<=1, oSum<=0, phase<=0. This is legal from any state.
- In RUN, ADDR/DATA transfers are acked but ignored: no WE, oErr<=1.
- Every event is acked, including errors. There is never more than one event per handshake, since the host waits for oAck.
- oIRAM_WE is never high for two consecutive cycles; the minimum event spacing is 4 cycles.
- Async reset mid-pair or mid-WE: WE drops immediately, the pending byte is lost, and the core returns to reset.

Test Plan:
1. Hold iStb=1 through reset and release it -> outputs at reset values, no WE, oAck=1 after 3 edges, oCoreRst=1.
2. Latency: toggle iStb with NOP -> oAck toggles at the 3rd rising edge after the iStb change (edge k+2 with k the sampling edge).
3. ADDR 0x01,0xFE -> oIRAM_Addr=0x1FE.
   - DATA 0x12,0x34 -> one WE cycle with addr 0x1FE, data 0x1234; oIRAM_Addr becomes 0x1FF.
   - DATA 0xAB,0xCD -> write at 0x1FF; oIRAM_Addr wraps to 0x000; oSum=0xBE01.
4. ADDR 0x00 then DATA 0x55 -> oErr=1, no WE, oIRAM_Addr unchanged; NOP -> oErr=0.
5. RUN 0x01 -> oCoreRst=0; DATA 0x11,0x22 -> no WE, oErr=1.
   - HALT 0x00 -> oCoreRst=1, oSum=0.
   - RUN after a single DATA byte -> oErr=1, oCoreRst stays 1.
6. Assert iRst between the high and low DATA bytes -> no write ever occurs, phase=0, oIRAM_Addr=0, oCoreRst=1.
   - After priming, a fresh two-byte DATA pair writes to address 0.
